// File: rtl/pcs_tx_symbol_scheduler.sv
// Purpose: serialises MAC words LSB byte first into the 8b/10b encoder; with PCS_SKP_INSERT_EN defined, it also inserts SKP ordered sets.
// Latency: the byte0 register loads on the accepting edge; the remaining bytes follow on consecutive cycles; there is no bubble between words.
// Backpressure: Ready is asserted only at a word/ordered-set boundary with no SKP pending; a pending SKP holds the MAC word.
module pcs_tx_symbol_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic                  PCLK,
    input  logic                  Reset_n,
    input  logic [DATA_WIDTH-1:0] MAC_TX_Data,
    input  logic                  MAC_Data_Valid,
    output logic                  MAC_Data_Ready,
    output logic [7:0]            TxData,
    output logic                  TxDataK,
    output logic                  Encoder_en,
    output logic                  Skp_Busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

`ifdef PCS_SKP_INSERT_EN
    localparam int IVW = $clog2(SKP_INTERVAL);
    localparam logic [IVW-1:0] IVL_LAST = IVW'(SKP_INTERVAL - 1);
    localparam logic [2:0]     SKP_LAST = 3'(SKP_COUNT);
    localparam logic [7:0]     SYM_COM  = 8'hBC;
    localparam logic [7:0]     SYM_SKP  = 8'h1C;

    typedef enum logic [1:0] {IDLE, DATA, SKP} state_t;
`else
    typedef enum logic [0:0] {IDLE, DATA} state_t;
`endif

    state_t                state_q, state_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            tx_dat_d;
    logic                  enc_en_d;
    logic                  boundary;
    logic                  skp_pending;

`ifdef PCS_SKP_INSERT_EN
    logic [2:0]            skp_cnt_q, skp_cnt_d;
    logic [IVW-1:0]        ivl_cnt_q;
    logic                  ivl_hit;
    logic                  clr_pending;
    logic                  tx_k_d;
    logic                  busy_d;

    assign ivl_hit = (ivl_cnt_q == IVL_LAST);
`else
    assign skp_pending = 1'b0;
    assign TxDataK     = 1'b0;
    assign Skp_Busy    = 1'b0;
`endif

    // Boundary: the point at which a new word or a SKP ordered set may start.
    always_comb begin
        boundary = 1'b0;
        case (state_q)
            IDLE:    boundary = 1'b1;
            DATA:    boundary = (byte_cnt_q == LAST_BYTE);
`ifdef PCS_SKP_INSERT_EN
            SKP:     boundary = (skp_cnt_q == SKP_LAST);
`endif
            default: boundary = 1'b0;
        endcase
    end

    assign MAC_Data_Ready = boundary & ~skp_pending;

    // Next state and next symbol; a pending SKP takes priority over a waiting word.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        tx_dat_d   = 8'h00;
        enc_en_d   = 1'b0;
`ifdef PCS_SKP_INSERT_EN
        skp_cnt_d   = skp_cnt_q;
        clr_pending = 1'b0;
        tx_k_d      = 1'b0;
        busy_d      = 1'b0;
`endif
        if (!boundary) begin
            case (state_q)
                DATA: begin
                    // The holding register shifts so the next byte is always in the low lane.
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    tx_dat_d   = word_q[7:0];
                    word_d     = word_q >> 8;
                    enc_en_d   = 1'b1;
                end
`ifdef PCS_SKP_INSERT_EN
                SKP: begin
                    skp_cnt_d = skp_cnt_q + 3'd1;
                    tx_dat_d  = SYM_SKP;
                    tx_k_d    = 1'b1;
                    enc_en_d  = 1'b1;
                    busy_d    = 1'b1;
                end
`endif
                default: ;
            endcase
`ifdef PCS_SKP_INSERT_EN
        end else if (skp_pending) begin
            state_d     = SKP;
            skp_cnt_d   = 3'd0;
            tx_dat_d    = SYM_COM;
            tx_k_d      = 1'b1;
            enc_en_d    = 1'b1;
            busy_d      = 1'b1;
            clr_pending = 1'b1;
`endif
        end else if (MAC_Data_Valid) begin
            state_d    = DATA;
            byte_cnt_d = '0;
            tx_dat_d   = MAC_TX_Data[7:0];
            word_d     = MAC_TX_Data >> 8;
            enc_en_d   = 1'b1;
        end else begin
            state_d    = IDLE;
            byte_cnt_d = '0;
        end
    end

    // State, holding register and registered encoder outputs; reset discards any partial word.
    always_ff @(posedge PCLK) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            TxData     <= 8'h00;
            Encoder_en <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            TxData     <= tx_dat_d;
            Encoder_en <= enc_en_d;
        end
    end

`ifdef PCS_SKP_INSERT_EN
    // SKP scheduling: a free-running interval counter raises a request that is cleared when COM goes out.
    always_ff @(posedge PCLK) begin
        if (!Reset_n) begin
            ivl_cnt_q   <= '0;
            skp_pending <= 1'b0;
            skp_cnt_q   <= 3'd0;
            TxDataK     <= 1'b0;
            Skp_Busy    <= 1'b0;
        end else begin
            ivl_cnt_q <= ivl_hit ? '0 : ivl_cnt_q + IVW'(1);
            if (ivl_hit) begin
                skp_pending <= 1'b1;
            end else if (clr_pending) begin
                skp_pending <= 1'b0;
            end
            skp_cnt_q <= skp_cnt_d;
            TxDataK   <= tx_k_d;
            Skp_Busy  <= busy_d;
        end
    end
`endif

endmodule

// File: tb/tb_pcs_tx_symbol_scheduler.sv
// Directed bench for pcs_tx_symbol_scheduler (DATA_WIDTH=32, SKP_INTERVAL=20, SKP_COUNT=3).
// The SKP preemption case runs when PCS_SKP_INSERT_EN is defined; the 10-word plain stream runs otherwise.
`timescale 1ns/1ps
module tb_pcs_tx_symbol_scheduler;
    logic        PCLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] MAC_TX_Data = 32'h0;
    logic        MAC_Data_Valid = 1'b0;
    logic        MAC_Data_Ready;
    logic [7:0]  TxData;
    logic        TxDataK;
    logic        Encoder_en;
    logic        Skp_Busy;

    int total = 0;
    int bad   = 0;
    int widx  = 0;

    logic [7:0] exp2 [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp3 [0:7] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};

    pcs_tx_symbol_scheduler #(
        .DATA_WIDTH  (32),
        .SKP_INTERVAL(20),
        .SKP_COUNT   (3)
    ) dut (
        .PCLK          (PCLK),
        .Reset_n       (Reset_n),
        .MAC_TX_Data   (MAC_TX_Data),
        .MAC_Data_Valid(MAC_Data_Valid),
        .MAC_Data_Ready(MAC_Data_Ready),
        .TxData        (TxData),
        .TxDataK       (TxDataK),
        .Encoder_en    (Encoder_en),
        .Skp_Busy      (Skp_Busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_sym(input string tag, input logic [7:0] d, input logic k,
                             input logic en, input logic busy);
        check({tag, "_dat"},  32'(TxData),     32'(d));
        check({tag, "_k"},    32'(TxDataK),    32'(k));
        check({tag, "_en"},   32'(Encoder_en), 32'(en));
        check({tag, "_busy"}, 32'(Skp_Busy),   32'(busy));
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [31:0] mk_word(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Holds reset for n edges with Valid asserted; outputs must stay zero throughout.
    task automatic do_reset(input int n);
        Reset_n        = 1'b0;
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = 32'h5A5A5A5A;
        for (int i = 0; i < n; i++) begin
            tick();
            check_sym($sformatf("rst%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end
        MAC_Data_Valid = 1'b0;
        Reset_n        = 1'b1;
    endtask

    // MAC model: offers mk_word(widx) until nw words are taken, advancing on each accept.
    task automatic stream_tick(input int nw);
        logic acc;
        acc = MAC_Data_Valid & MAC_Data_Ready;
        tick();
        if (acc) widx++;
        MAC_Data_Valid = (widx < nw);
        MAC_TX_Data    = mk_word(widx);
    endtask

    initial begin
        // Reset with Valid held, then accept on the first edge after release.
        do_reset(2);
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = 32'h04030201;
        tick();
        check_sym("t1_first", 8'h01, 1'b0, 1'b1, 1'b0);
        MAC_Data_Valid = 1'b0;
        repeat (4) tick();
        check_sym("t1_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Single word, LSB byte first, then idle.
        do_reset(1);
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = 32'h44332211;
        check("t2_rdy_idle", 32'(MAC_Data_Ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            MAC_Data_Valid = 1'b0;
            check_sym($sformatf("t2_b%0d", i), exp2[i], 1'b0, 1'b1, 1'b0);
            check($sformatf("t2_rdy%0d", i), 32'(MAC_Data_Ready), 32'(i == 3));
        end
        tick();
        check_sym("t2_end", 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back words with no bubble.
        do_reset(1);
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = 32'hA3A2A1A0;
        check("t3_rdy_idle", 32'(MAC_Data_Ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) MAC_TX_Data = 32'hB3B2B1B0;
            if (i == 4) MAC_Data_Valid = 1'b0;
            check_sym($sformatf("t3_b%0d", i), exp3[i], 1'b0, 1'b1, 1'b0);
            if (i < 7) check($sformatf("t3_rdy%0d", i), 32'(MAC_Data_Ready), 32'(i == 3));
        end
        tick();
        check_sym("t3_end", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset during byte1 discards the rest of the word.
        do_reset(1);
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = 32'hDDCCBBAA;
        tick();
        MAC_Data_Valid = 1'b0;
        check_sym("t5_b0", 8'hAA, 1'b0, 1'b1, 1'b0);
        tick();
        check_sym("t5_b1", 8'hBB, 1'b0, 1'b1, 1'b0);
        Reset_n = 1'b0;
        tick();
        check_sym("t5_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_sym($sformatf("t5_after%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end

`ifdef PCS_SKP_INSERT_EN
        // Continuous stream; counter hits 19 on edge 20, so COM goes out at edge 21 after word 4.
        do_reset(1);
        widx           = 0;
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = mk_word(0);
        for (int c = 1; c <= 37; c++) begin
            logic [7:0] ed;
            logic       ek, een, eb, er;
            stream_tick(8);
            if (c <= 20) begin
                ed = 8'(c - 1); ek = 1'b0; een = 1'b1; eb = 1'b0;
                er = (c % 4 == 0) && (c != 20);
            end else if (c == 21) begin
                ed = 8'hBC; ek = 1'b1; een = 1'b1; eb = 1'b1; er = 1'b0;
            end else if (c <= 24) begin
                ed = 8'h1C; ek = 1'b1; een = 1'b1; eb = 1'b1; er = (c == 24);
            end else if (c <= 36) begin
                ed = 8'(c - 5); ek = 1'b0; een = 1'b1; eb = 1'b0; er = (c % 4 == 0);
            end else begin
                ed = 8'h00; ek = 1'b0; een = 1'b0; eb = 1'b0; er = 1'b1;
            end
            check_sym($sformatf("t4_c%0d", c), ed, ek, een, eb);
            check($sformatf("t4_rdy%0d", c), 32'(MAC_Data_Ready), 32'(er));
        end
`else
        // No SKP logic: 10 words give 40 contiguous data bytes, never K-flagged.
        do_reset(1);
        widx           = 0;
        MAC_Data_Valid = 1'b1;
        MAC_TX_Data    = mk_word(0);
        for (int c = 1; c <= 41; c++) begin
            stream_tick(10);
            if (c <= 40) begin
                check_sym($sformatf("t6_c%0d", c), 8'(c - 1), 1'b0, 1'b1, 1'b0);
                check($sformatf("t6_rdy%0d", c), 32'(MAC_Data_Ready), 32'(c % 4 == 0));
            end else begin
                check_sym("t6_end", 8'h00, 1'b0, 1'b0, 1'b0);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
